delay_timer_arbiter: RTL and testbench

- Shares one 2-second delay timer among several game FSMs: dealer-draw pause, score display hold and result/bust hold.
- Generates the 2 kHz tick internally from clk_50M with a prescaler, so there is no second clock domain.
- Grants the timer to one requester at a time using round-robin arbitration.
- Pulses a per-requester done strobe when that requester's delay expires.

---
 rtl/delay_timer_arbiter.sv | 167 ++++++++++++++++
 tb/tb_delay_timer_arbiter.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/delay_timer_arbiter.sv
// delay_timer_arbiter
//   Shares one fixed-length delay timer among N_REQ game FSMs. A prescaler
//   derives the tick from clk_50M. Requesters are granted the timer one at a
//   time, and each receives a done strobe when its delay expires.
//
//   Build option: define DELAY_TIMER_FIXED_PRIO_EN to replace round-robin with
//   fixed priority (lowest index wins). That build has no pointer register.
//
// Ports
//   clk_50M    in   system clock
//   i_Reset    in   synchronous, active-high reset
//   i_Req      in   level requests, held until o_Done is seen
//   o_Grant    out  one-hot current owner, zero when idle
//   o_Done     out  one-cycle pulse on the owner bit when its delay ends
//   o_Busy     out  high in RUN and DONE
//   o_Elapsed  out  ticks elapsed in the current delay
//   o_Tick     out  prescaler tick, only in RUN
module delay_timer_arbiter #(
  parameter int N_REQ       = 3,
  parameter int TICK_DIV    = 25000,
  parameter int DELAY_TICKS = 4000,
  parameter int CW          = $clog2(DELAY_TICKS + 1)
) (
  input  logic             clk_50M,
  input  logic             i_Reset,
  input  logic [N_REQ-1:0] i_Req,
  output logic [N_REQ-1:0] o_Grant,
  output logic [N_REQ-1:0] o_Done,
  output logic             o_Busy,
  output logic [CW-1:0]    o_Elapsed,
  output logic             o_Tick
);

  localparam int PSW = $clog2(TICK_DIV);
  localparam int PW  = $clog2(N_REQ);

  generate
    if (TICK_DIV < 2 || DELAY_TICKS < 1 || N_REQ < 2 || N_REQ > 8) begin : g_bad_param
      $error("delay_timer_arbiter: parameter out of range");
    end
  endgenerate

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [N_REQ-1:0] done_q, done_d;
  logic [CW-1:0]    elapsed_q, elapsed_d;
  logic [PSW-1:0]   presc_q, presc_d;
`ifndef DELAY_TIMER_FIXED_PRIO_EN
  logic [PW-1:0]    ptr_q, ptr_d;
`endif

  logic          found;
  logic [PW-1:0] win;
  logic          tick;
  logic          cancel;

  // Winner selection from the current request vector.
  always_comb begin
    int idx;
    idx   = 0;
    found = 1'b0;
    win   = '0;
    for (int k = 0; k < N_REQ; k++) begin
`ifdef DELAY_TIMER_FIXED_PRIO_EN
      idx = k;
`else
      idx = (int'(ptr_q) + k) % N_REQ;
`endif
      if (!found && i_Req[idx]) begin
        found = 1'b1;
        win   = PW'(idx);
      end
    end
  end

  assign tick   = (state_q == S_RUN) && (presc_q == PSW'(TICK_DIV - 1));
  // The owner dropping its request mid-run abandons the delay.
  assign cancel = |(grant_q & ~i_Req);

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    done_d    = '0;
    elapsed_d = elapsed_q;
    presc_d   = presc_q;
`ifndef DELAY_TIMER_FIXED_PRIO_EN
    ptr_d     = ptr_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (found) begin
          state_d   = S_RUN;
          grant_d   = N_REQ'(1) << win;
          presc_d   = '0;
          elapsed_d = '0;
`ifndef DELAY_TIMER_FIXED_PRIO_EN
          ptr_d     = (win == PW'(N_REQ - 1)) ? '0 : win + PW'(1);
`endif
        end
      end
      S_RUN: begin
        if (cancel) begin
          state_d   = S_IDLE;
          grant_d   = '0;
          elapsed_d = '0;
          presc_d   = '0;
        end else begin
          presc_d = tick ? '0 : presc_q + PSW'(1);
          if (tick) begin
            if (elapsed_q == CW'(DELAY_TICKS - 1)) begin
              state_d   = S_DONE;
              elapsed_d = CW'(DELAY_TICKS);
              done_d    = grant_q;
            end else begin
              elapsed_d = elapsed_q + CW'(1);
            end
          end
        end
      end
      S_DONE: begin
        // Grant is released here; the requester drops its request on the same
        // edge, so IDLE never sees a stale request from the finished owner.
        state_d   = S_IDLE;
        grant_d   = '0;
        elapsed_d = '0;
        presc_d   = '0;
      end
      default: begin
        state_d   = S_IDLE;
        grant_d   = '0;
        elapsed_d = '0;
        presc_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_50M) begin
    if (i_Reset) begin
      state_q   <= S_IDLE;
      grant_q   <= '0;
      done_q    <= '0;
      elapsed_q <= '0;
      presc_q   <= '0;
`ifndef DELAY_TIMER_FIXED_PRIO_EN
      ptr_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      done_q    <= done_d;
      elapsed_q <= elapsed_d;
      presc_q   <= presc_d;
`ifndef DELAY_TIMER_FIXED_PRIO_EN
      ptr_q     <= ptr_d;
`endif
    end
  end

  assign o_Grant   = grant_q;
  assign o_Done    = done_q;
  assign o_Busy    = (state_q != S_IDLE);
  assign o_Elapsed = elapsed_q;
  assign o_Tick    = tick;

endmodule

// File: tb/tb_delay_timer_arbiter.sv
module tb_delay_timer_arbiter;

  localparam int N_REQ = 3;
  localparam int TDIV  = 4;
  localparam int DLY   = 5;
  localparam int CW    = $clog2(DLY + 1);

  logic             clk_50M = 1'b0;
  logic             i_Reset;
  logic [N_REQ-1:0] i_Req;
  logic [N_REQ-1:0] o_Grant;
  logic [N_REQ-1:0] o_Done;
  logic             o_Busy;
  logic [CW-1:0]    o_Elapsed;
  logic             o_Tick;

  int n_tests = 0;
  int n_fail  = 0;

  delay_timer_arbiter #(
    .N_REQ(N_REQ), .TICK_DIV(TDIV), .DELAY_TICKS(DLY)
  ) dut (
    .clk_50M  (clk_50M),
    .i_Reset  (i_Reset),
    .i_Req    (i_Req),
    .o_Grant  (o_Grant),
    .o_Done   (o_Done),
    .o_Busy   (o_Busy),
    .o_Elapsed(o_Elapsed),
    .o_Tick   (o_Tick)
  );

  always #10 clk_50M = ~clk_50M;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk_50M);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_grant"},   32'(o_Grant),   0);
    chk({tag, "_done"},    32'(o_Done),    0);
    chk({tag, "_busy"},    32'(o_Busy),    0);
    chk({tag, "_elapsed"}, 32'(o_Elapsed), 0);
    chk({tag, "_tick"},    32'(o_Tick),    0);
  endtask

  // Entered in the first RUN cycle of owner g. Runs through DONE and into the
  // following IDLE cycle, where i_Req is set to 'after'. mid_req is applied
  // at RUN cycle mid_c (0 = never).
  task automatic serve(input logic [2:0] g, input logic [2:0] mid_req,
                       input int mid_c, input logic [2:0] after);
    chk("grant",     32'(o_Grant),   32'(g));
    chk("elapsed0",  32'(o_Elapsed), 0);
    chk("tick0",     32'(o_Tick),    0);
    chk("busy0",     32'(o_Busy),    1);
    for (int c = 1; c < TDIV * DLY; c++) begin
      step();
      if (c == mid_c) i_Req = mid_req;
      chk("run_grant",   32'(o_Grant),   32'(g));
      chk("run_done",    32'(o_Done),    0);
      chk("run_tick",    32'(o_Tick),    32'((c % TDIV) == TDIV - 1));
      chk("run_elapsed", 32'(o_Elapsed), 32'(c / TDIV));
    end
    step();
    chk("done_pulse",   32'(o_Done),    32'(g));
    chk("done_grant",   32'(o_Grant),   32'(g));
    chk("done_elapsed", 32'(o_Elapsed), DLY);
    chk("done_tick",    32'(o_Tick),    0);
    chk("done_busy",    32'(o_Busy),    1);
    step();
    i_Req = after;
    chk_idle("post_done");
  endtask

  initial begin
    i_Reset = 1'b1;
    i_Req   = '0;
    step();
    step();
    chk_idle("reset");

    // Single request
    i_Reset = 1'b0;
    i_Req   = 3'b001;
    step();
    serve(3'b001, 3'b001, 0, 3'b000);
    step();
    chk("no_regrant", 32'(o_Grant), 0);

    // Round-robin from a fresh pointer
    i_Reset = 1'b1;
    step();
    i_Reset = 1'b0;
    i_Req   = 3'b111;
    step();
    serve(3'b001, 3'b111, 0, 3'b110);
    step();
    serve(3'b010, 3'b110, 0, 3'b100);
    step();
    serve(3'b100, 3'b100, 0, 3'b000);
    step();
    chk("rr_end_idle", 32'(o_Grant), 0);

    // Cancel: index 1 owns, index 2 pending, owner drops at RUN cycle 7
    i_Req = 3'b010;
    step();
    chk("cx_grant", 32'(o_Grant), 32'(3'b010));
    i_Req = 3'b110;
    for (int c = 1; c <= 7; c++) begin
      step();
      chk("cx_run_grant",   32'(o_Grant),   32'(3'b010));
      chk("cx_run_elapsed", 32'(o_Elapsed), 32'(c / TDIV));
    end
    i_Req = 3'b100;
    step();
    chk_idle("cancel");
    step();
    chk("cx_pending_grant", 32'(o_Grant), 32'(3'b100));

    // Reset mid-run at elapsed 3
    for (int c = 1; c <= 12; c++) begin
      step();
      chk("rst_run_done", 32'(o_Done), 0);
    end
    chk("rst_pre_elapsed", 32'(o_Elapsed), 3);
    i_Reset = 1'b1;
    step();
    chk_idle("midrun_reset");

    // Pointer was reset: 111 goes to index 0; index 2 arrives late
    i_Reset = 1'b0;
    i_Req   = 3'b111;
    step();
    serve(3'b001, 3'b101, 5, 3'b100);
    step();
    chk("late_grant", 32'(o_Grant), 32'(3'b100));
    i_Req = 3'b000;
    step();
    chk("late_cancel", 32'(o_Grant), 0);

`ifdef DELAY_TIMER_FIXED_PRIO_EN
    i_Req = 3'b110;
    step();
    serve(3'b010, 3'b110, 0, 3'b110);
    step();
    chk("fp_regrant", 32'(o_Grant), 32'(3'b010));
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
